// File: rtl/zircon_segled_scan_ctrl.sv
// Scan scheduler for the 6-digit multiplexed 7-segment display: time-slices the segment bus,
// applies PWM brightness, dead time and leading-zero blanking, commits updates at frame boundaries.
module zircon_segled_scan_ctrl #(
   parameter int unsigned SCAN_DIV    = 50000,
   parameter int unsigned DEAD        = 64,
   parameter bit          CS_ACT_LOW  = 1'b1,
   parameter bit          SEG_ACT_LOW = 1'b1
) (
   input  logic        csi_clk,
   input  logic        rsi_reset_n,
   input  logic        enable,
   input  logic        upd_req,
   input  logic [23:0] upd_digits,
   input  logic [5:0]  upd_dp,
   input  logic [5:0]  upd_blank,
   input  logic        upd_lz_en,
   input  logic [3:0]  upd_bright,
   output logic        upd_ack,
   output logic        frame_done,
   output logic [2:0]  scan_idx,
   output logic [5:0]  coe_seg_cs,
   output logic [7:0]  coe_seg_data
);

   localparam int unsigned CW       = $clog2(SCAN_DIV);
   localparam int unsigned PH_DIV   = SCAN_DIV / 16;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
   localparam logic [CW-1:0] CNT_PH   = CW'(PH_DIV);
   localparam logic [2:0]    IDX_LAST = 3'd5;
   localparam logic [5:0]    CS_OFF   = CS_ACT_LOW  ? 6'h3F : 6'h00;
   localparam logic [7:0]    SEG_OFF  = SEG_ACT_LOW ? 8'hFF : 8'h00;

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [23:0]   sh_digits;
   logic [5:0]    sh_dp;
   logic [5:0]    sh_blank;
   logic          sh_lz;
   logic [3:0]    sh_bright;

   logic          tick_c;
   logic          boundary_c;
   logic [3:0]    phase_c;
   logic [3:0]    cur_digit_c;
   logic [5:0]    lz_dark_c;
   logic          lit_c;
   logic [5:0]    cs_hot_c;
   logic [7:0]    seg_hi_c;
   logic          zero_run;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         4'hF: hex7 = 7'h71;
      endcase
   endfunction

   assign tick_c     = (cnt == CNT_LAST);
   assign boundary_c = tick_c && (idx == IDX_LAST);

   // Slot prescaler and digit index
   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         cnt <= '0;
         idx <= 3'd0;
      end else if (tick_c) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Shadow copy only changes on a frame boundary so a frame never tears
   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         sh_digits <= 24'h0;
         sh_dp     <= 6'h00;
         sh_blank  <= 6'h3F;
         sh_lz     <= 1'b0;
         sh_bright <= 4'h0;
      end else if (boundary_c && upd_req) begin
         sh_digits <= upd_digits;
         sh_dp     <= upd_dp;
         sh_blank  <= upd_blank;
         sh_lz     <= upd_lz_en;
         sh_bright <= upd_bright;
      end
   end

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         upd_ack    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         upd_ack    <= boundary_c && upd_req;
         frame_done <= boundary_c;
      end
   end

   // Leading-zero mask: digit i dark while digits 0..i are all zero (digit 5 always shown)
   always_comb begin
      lz_dark_c = 6'h00;
      zero_run  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         zero_run     = zero_run && (sh_digits[4*i +: 4] == 4'h0);
         lz_dark_c[i] = sh_lz && zero_run;
      end
   end

   always_comb begin
      phase_c     = 4'(cnt / CNT_PH);
      cur_digit_c = sh_digits[{idx, 2'b00} +: 4];
      cs_hot_c    = 6'b000001 << idx;
      seg_hi_c    = {sh_dp[idx], hex7(cur_digit_c)};
      lit_c       = enable && (cnt >= CNT_DEAD) && (phase_c <= sh_bright)
                    && !sh_blank[idx] && !lz_dark_c[idx];
   end

   // Registered pin drivers
   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         coe_seg_cs   <= CS_OFF;
         coe_seg_data <= SEG_OFF;
         scan_idx     <= 3'd0;
      end else begin
         scan_idx <= idx;
         if (lit_c) begin
            coe_seg_cs   <= CS_ACT_LOW  ? ~cs_hot_c : cs_hot_c;
            coe_seg_data <= SEG_ACT_LOW ? ~seg_hi_c : seg_hi_c;
         end else begin
            coe_seg_cs   <= CS_OFF;
            coe_seg_data <= SEG_OFF;
         end
      end
   end

endmodule

// File: tb/tb_zircon_segled_scan_ctrl.sv
// Bench for zircon_segled_scan_ctrl: cycle scoreboard of pin values plus directed frame-level checks.
module tb_zircon_segled_scan_ctrl;

   localparam int SLOT  = 32;
   localparam int FRAME = 6 * SLOT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   logic        upd_req = 1'b0;
   logic [23:0] upd_digits = 24'h0;
   logic [5:0]  upd_dp = 6'h0;
   logic [5:0]  upd_blank = 6'h0;
   logic        upd_lz_en = 1'b0;
   logic [3:0]  upd_bright = 4'h0;
   logic        upd_ack;
   logic        frame_done;
   logic [2:0]  scan_idx;
   logic [5:0]  coe_seg_cs;
   logic [7:0]  coe_seg_data;

   int errors = 0;
   int checks = 0;

   zircon_segled_scan_ctrl #(
      .SCAN_DIV(32), .DEAD(2), .CS_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
   ) dut (
      .csi_clk(clk), .rsi_reset_n(rst_n), .enable(enable), .upd_req(upd_req),
      .upd_digits(upd_digits), .upd_dp(upd_dp), .upd_blank(upd_blank),
      .upd_lz_en(upd_lz_en), .upd_bright(upd_bright), .upd_ack(upd_ack),
      .frame_done(frame_done), .scan_idx(scan_idx), .coe_seg_cs(coe_seg_cs),
      .coe_seg_data(coe_seg_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [5:0] cs;
      logic [7:0] seg;
      logic [2:0] idx;
      logic       ack;
      logic       fd;
   } exp_t;

   exp_t sb[$];

   // Reference model: active-high gfedcba table
   logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int          m_cnt;
   int          m_idx;
   logic [23:0] m_dig;
   logic [5:0]  m_dp, m_blank;
   logic        m_lz;
   logic [3:0]  m_bright;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_cnt = 0; m_idx = 0; m_dig = 24'h0; m_dp = 6'h0; m_blank = 6'h3F;
            m_lz = 1'b0; m_bright = 4'h0;
            sb.delete();
         end else begin
            exp_t e;
            bit   lit, allz, bnd;
            logic [3:0] d;
            logic [7:0] hi;
            allz = 1'b1;
            for (int i = 0; i <= m_idx; i++) begin
               d = m_dig[4*i +: 4];
               if (d != 4'h0) allz = 1'b0;
            end
            d   = m_dig[4*m_idx +: 4];
            lit = enable && (m_cnt >= 2) && ((m_cnt / 2) <= int'(m_bright))
                  && !m_blank[m_idx] && !(m_lz && allz && m_idx < 5);
            hi  = {m_dp[m_idx], dec[d]};
            bnd = (m_cnt == SLOT - 1) && (m_idx == 5);
            e.cs  = lit ? ~(6'b000001 << m_idx) : 6'h3F;
            e.seg = lit ? ~hi : 8'hFF;
            e.idx = 3'(m_idx);
            e.ack = bnd && upd_req;
            e.fd  = bnd;
            sb.push_back(e);
            if (bnd && upd_req) begin
               m_dig = upd_digits; m_dp = upd_dp; m_blank = upd_blank;
               m_lz = upd_lz_en; m_bright = upd_bright;
            end
            if (m_cnt == SLOT - 1) begin
               m_cnt = 0;
               m_idx = (m_idx == 5) ? 0 : m_idx + 1;
            end else begin
               m_cnt++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_cs", 32'(coe_seg_cs), 32'(e.cs));
            check("sb_seg", 32'(coe_seg_data), 32'(e.seg));
            check("sb_idx", 32'(scan_idx), 32'(e.idx));
            check("sb_ack", 32'(upd_ack), 32'(e.ack));
            check("sb_fd", 32'(frame_done), 32'(e.fd));
         end
      end
   end

   task automatic measure(input int n, input logic [5:0] cpat, input logic [7:0] spat,
                          output int hits, output int act, output int acks, output int fds);
      hits = 0; act = 0; acks = 0; fds = 0;
      repeat (n) begin
         @(negedge clk);
         if (coe_seg_cs == cpat && coe_seg_data == spat) hits++;
         if (coe_seg_cs != 6'h3F) act++;
         if (upd_ack) acks++;
         if (frame_done) fds++;
      end
   endtask

   task automatic wait_ack(output int waited);
      waited = 0;
      while (waited < 600) begin
         @(negedge clk);
         waited++;
         if (upd_ack) return;
      end
      check("ack_timeout", 32'(waited), 32'(0));
   endtask

   task automatic do_update(input logic [23:0] dig, input logic [5:0] dp, input logic [5:0] blank,
                            input logic lz, input logic [3:0] br);
      int w;
      upd_digits = dig; upd_dp = dp; upd_blank = blank; upd_lz_en = lz; upd_bright = br;
      upd_req = 1'b1;
      wait_ack(w);
      upd_req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int hits, act, acks, fds, w;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_cs", 32'(coe_seg_cs), 32'h3F);
      check("rst_seg", 32'(coe_seg_data), 32'hFF);
      check("rst_ack", 32'(upd_ack), 32'h0);
      check("rst_fd", 32'(frame_done), 32'h0);
      check("rst_idx", 32'(scan_idx), 32'h0);
      rst_n = 1'b1;

      // Dark for two frames with no update
      measure(2 * FRAME, 6'h3F, 8'hFF, hits, act, acks, fds);
      check("t1_dark", 32'(act), 32'd0);
      check("t1_acks", 32'(acks), 32'd0);
      check("t1_fds", 32'(fds), 32'd2);

      // Mid-frame request waits for the next boundary
      repeat (50) @(negedge clk);
      upd_digits = 24'h654321; upd_dp = 6'b000001; upd_blank = 6'h0;
      upd_lz_en = 1'b0; upd_bright = 4'hF; upd_req = 1'b1;
      wait_ack(w);
      check("t2_ack_wait", 32'(w), 32'(FRAME - 50));
      check("t2_ack_fd", 32'(frame_done), 32'd1);
      upd_req = 1'b0;
      measure(FRAME, 6'b111110, 8'h79, hits, act, acks, fds);
      check("t2_slot0", 32'(hits), 32'd30);
      check("t2_active", 32'(act), 32'd180);
      check("t2_ack_once", 32'(acks), 32'd0);
      measure(FRAME, 6'b011111, 8'h82, hits, act, acks, fds);
      check("t2_slot5", 32'(hits), 32'd30);

      // Leading-zero suppression
      do_update(24'h070000, 6'h0, 6'h0, 1'b1, 4'hF);
      measure(FRAME, 6'b101111, 8'hF8, hits, act, acks, fds);
      check("t3_slot4", 32'(hits), 32'd30);
      check("t3_active", 32'(act), 32'd60);
      do_update(24'h000000, 6'h0, 6'h0, 1'b1, 4'hF);
      measure(FRAME, 6'b011111, 8'hC0, hits, act, acks, fds);
      check("t3_zero_slot5", 32'(hits), 32'd30);
      check("t3_zero_active", 32'(act), 32'd30);

      // Brightness
      do_update(24'h654321, 6'h0, 6'h0, 1'b0, 4'd3);
      measure(FRAME, 6'b111110, 8'hF9, hits, act, acks, fds);
      check("t4_b3_slot0", 32'(hits), 32'd6);
      check("t4_b3_active", 32'(act), 32'd36);
      do_update(24'h654321, 6'h0, 6'h0, 1'b0, 4'd0);
      measure(FRAME, 6'h3F, 8'hFF, hits, act, acks, fds);
      check("t4_b0_active", 32'(act), 32'd0);

      // Request raised exactly on the boundary cycle
      repeat (FRAME - 1) @(negedge clk);
      upd_digits = 24'hABCDEF; upd_dp = 6'h0; upd_blank = 6'h0;
      upd_lz_en = 1'b0; upd_bright = 4'hF; upd_req = 1'b1;
      @(negedge clk);
      check("t5_edge_ack", 32'(upd_ack), 32'd1);
      upd_req = 1'b0;
      measure(FRAME, 6'b111110, 8'h8E, hits, act, acks, fds);
      check("t5_edge_slot0", 32'(hits), 32'd30);

      // Request held across two boundaries is captured twice
      upd_req = 1'b1;
      measure(FRAME, 6'b111110, 8'h8E, hits, act, acks, fds);
      w = acks;
      measure(FRAME, 6'b111110, 8'h8E, hits, act, acks, fds);
      check("t5_two_acks", 32'(w + acks), 32'd2);
      upd_req = 1'b0;

      // Disabled: dark, but handshake and frame pulses continue
      enable = 1'b0; upd_req = 1'b1;
      measure(FRAME, 6'h3F, 8'hFF, hits, act, acks, fds);
      upd_req = 1'b0;
      check("t5_dis_active", 32'(act), 32'd0);
      check("t5_dis_acks", 32'(acks), 32'd1);
      check("t5_dis_fds", 32'(fds), 32'd1);
      enable = 1'b1;

      // Asynchronous reset in the middle of slot 3
      do_update(24'h654321, 6'h0, 6'h0, 1'b0, 4'hF);
      repeat (3 * SLOT + 10) @(negedge clk);
      check("t6_pre_lit", 32'(coe_seg_cs), 32'(6'b110111));
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_cs", 32'(coe_seg_cs), 32'h3F);
      check("t6_async_seg", 32'(coe_seg_data), 32'hFF);
      check("t6_async_ack", 32'(upd_ack), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      measure(2 * FRAME, 6'h3F, 8'hFF, hits, act, acks, fds);
      check("t6_dark_after", 32'(act), 32'd0);
      check("t6_fds_after", 32'(fds), 32'd2);
      do_update(24'h654321, 6'h0, 6'h0, 1'b0, 4'hF);
      measure(FRAME, 6'b111110, 8'hF9, hits, act, acks, fds);
      check("t6_relit_slot0", 32'(hits), 32'd30);
      check("t6_relit_active", 32'(act), 32'd180);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
